stab_rate_driver: RTL

- Rate-selection controller that sits directly upstream of the variable clock divider.
- Produces the divider's 33-bit terminal count (MAX_VAL) from user button presses (manual mode) or a timed automatic ramp (ramp mode).
- Also provides a run enable and level index for display/LED logic.
- Button inputs arrive already debounced and synchronized to CLK.

---
 rtl/stab_rate_driver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stab_rate_driver.sv
// Rate-selection controller feeding the variable clock divider: turns button presses
// (manual) or a timed ramp into a registered 33-bit terminal count plus run/level status.
module stab_rate_driver #(
    parameter int          NUM_LEVELS = 8,
    parameter logic [32:0] BASE_VAL   = 33'd50_000_000,
    parameter logic [32:0] STEP_VAL   = 33'd5_000_000,
    parameter logic [32:0] RAMP_TICKS = 33'd100_000_000,
    localparam int         LW         = $clog2(NUM_LEVELS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BTN_START,
    input  logic          BTN_STOP,
    input  logic          BTN_UP,
    input  logic          BTN_DN,
    input  logic          MODE,
    output logic [32:0]   MAX_VAL,
    output logic [LW-1:0] LEVEL,
    output logic          RUN_EN,
    output logic          RAMP_DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MANUAL,
        S_RAMP
    } state_t;

    localparam logic [LW-1:0] TOP_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] ONE_LEVEL = LW'(1);

    state_t        state_p0, state_nxt;
    logic [LW-1:0] level_p0, level_nxt;
    logic [32:0]   cnt_p0, cnt_nxt;
    logic          run_en_p0, run_en_nxt;
    logic          ramp_done_p0, ramp_done_nxt;
    logic [32:0]   max_val_p1;

    logic          start_prev, stop_prev, up_prev, dn_prev;
    logic          armed_p0;
    logic          start_e, stop_e, up_e, dn_e;

    function automatic logic [32:0] calc_max_val(input logic [LW-1:0] lvl);
        return BASE_VAL - (33'(lvl) * STEP_VAL);
    endfunction

    // armed_p0 masks the first post-reset cycle so a button held through reset
    // release only reloads its prev register instead of producing an edge.
    assign start_e = BTN_START & ~start_prev & armed_p0;
    assign stop_e  = BTN_STOP  & ~stop_prev  & armed_p0;
    assign up_e    = BTN_UP    & ~up_prev    & armed_p0;
    assign dn_e    = BTN_DN    & ~dn_prev    & armed_p0;

    always_comb begin
        state_nxt = state_p0;
        level_nxt = level_p0;
        cnt_nxt   = cnt_p0;
        if (stop_e) begin
            state_nxt = S_IDLE;
            level_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (state_p0)
                S_IDLE: begin
                    if (start_e) begin
                        state_nxt = MODE ? S_RAMP : S_MANUAL;
                        level_nxt = '0;
                        cnt_nxt   = '0;
                    end
                end
                S_MANUAL: begin
                    if (up_e && !dn_e && level_p0 != TOP_LEVEL) begin
                        level_nxt = level_p0 + ONE_LEVEL;
                    end else if (dn_e && !up_e && level_p0 != '0) begin
                        level_nxt = level_p0 - ONE_LEVEL;
                    end
                end
                S_RAMP: begin
                    if (level_p0 == TOP_LEVEL) begin
                        cnt_nxt = '0;
                    end else if (cnt_p0 == RAMP_TICKS - 33'd1) begin
                        cnt_nxt   = '0;
                        level_nxt = level_p0 + ONE_LEVEL;
                    end else begin
                        cnt_nxt = cnt_p0 + 33'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    level_nxt = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
        run_en_nxt    = (state_nxt != S_IDLE);
        ramp_done_nxt = (state_nxt == S_RAMP) && (level_nxt == TOP_LEVEL);
    end

    // Stage p0: state, level, ramp counter and status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0     <= S_IDLE;
            level_p0     <= '0;
            cnt_p0       <= '0;
            run_en_p0    <= 1'b0;
            ramp_done_p0 <= 1'b0;
            start_prev   <= 1'b0;
            stop_prev    <= 1'b0;
            up_prev      <= 1'b0;
            dn_prev      <= 1'b0;
            armed_p0     <= 1'b0;
        end else begin
            state_p0     <= state_nxt;
            level_p0     <= level_nxt;
            cnt_p0       <= cnt_nxt;
            run_en_p0    <= run_en_nxt;
            ramp_done_p0 <= ramp_done_nxt;
            start_prev   <= BTN_START;
            stop_prev    <= BTN_STOP;
            up_prev      <= BTN_UP;
            dn_prev      <= BTN_DN;
            armed_p0     <= 1'b1;
        end
    end

    // Stage p1: terminal count follows the level register by one cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            max_val_p1 <= BASE_VAL;
        end else begin
            max_val_p1 <= calc_max_val(level_p0);
        end
    end

    assign MAX_VAL   = max_val_p1;
    assign LEVEL     = level_p0;
    assign RUN_EN    = run_en_p0;
    assign RAMP_DONE = ramp_done_p0;

endmodule
